// File: rtl/lock_ctrl_pkg.sv
// Shared types, default parameters and helpers for the combination-lock sequencer.
// Optional entry timeout is enabled with the LOCK_ENTRY_TIMEOUT_EN macro.
package lock_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ENTER   = 2'd1,
        OPEN    = 2'd2,
        LOCKOUT = 2'd3
    } state_t;

    localparam int unsigned DEF_CODE_W      = 4;
    localparam logic [3:0]  DEF_CODE        = 4'b1101;
    localparam int unsigned DEF_MAX_FAIL    = 3;
    localparam int unsigned DEF_UNLK_CYC    = 8;
    localparam int unsigned DEF_LOCKOUT_CYC = 16;
    localparam int unsigned DEF_TIMEOUT_CYC = 32;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter with a zero flag; shared by OPEN, LOCKOUT and the entry timeout.
module lock_timer #(
    parameter int unsigned W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (en && (count_q != '0)) begin
            count_q <= count_q - W'(1);
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/lock_sequence_controller.sv
// Serial combination-lock sequencer: frames attempts, checks bits MSB first, unlock/lockout timing.
// Define LOCK_ENTRY_TIMEOUT_EN to abort an attempt after TIMEOUT_CYC idle cycles in ENTER.
module lock_sequence_controller
    import lock_ctrl_pkg::*;
#(
    parameter int unsigned          CODE_W      = DEF_CODE_W,
    parameter logic [CODE_W-1:0]    CODE        = DEF_CODE,
    parameter int unsigned          MAX_FAIL    = DEF_MAX_FAIL,
    parameter int unsigned          UNLK_CYC    = DEF_UNLK_CYC,
    parameter int unsigned          LOCKOUT_CYC = DEF_LOCKOUT_CYC,
    parameter int unsigned          TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                             CLK,
    input  logic                             CLR_L,
    input  logic                             START,
    input  logic                             X,
    input  logic                             X_VALID,
    output logic                             UNLK,
    output logic                             HINT,
    output logic                             LOCKED_OUT,
    output logic                             BUSY,
    output logic [$clog2(MAX_FAIL+1)-1:0]    FAIL_CNT
);

    localparam int unsigned BW = $clog2(CODE_W + 1);
    localparam int unsigned FW = $clog2(MAX_FAIL + 1);
    localparam int unsigned TW = $clog2(max3(UNLK_CYC, LOCKOUT_CYC, TIMEOUT_CYC) + 1);

    // Timer holds N-1 so its zero flag marks the last cycle of an N-cycle phase.
    localparam logic [TW-1:0] UNLK_LOAD = TW'(UNLK_CYC - 1);
    localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCKOUT_CYC - 1);
`ifdef LOCK_ENTRY_TIMEOUT_EN
    localparam logic [TW-1:0] TMO_LOAD  = TW'(TIMEOUT_CYC - 1);
`endif
    localparam logic [BW-1:0] LAST_BIT  = BW'(CODE_W - 1);

    state_t          state_q, state_d;
    logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
    logic            match_q, match_d;
    logic [FW-1:0]   fail_q, fail_d;
    logic            tmr_load, tmr_en, tmr_zero;
    logic [TW-1:0]   tmr_val;
    logic            code_bit;
    logic            attempt_done, attempt_ok;
    logic            unlk_d, hint_d, locked_d, busy_d;

    lock_timer #(.W(TW)) u_timer (
        .clk      (CLK),
        .rst_n    (CLR_L),
        .load     (tmr_load),
        .en       (tmr_en),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_comb begin
        code_bit = 1'b0;
        for (int unsigned i = 0; i < CODE_W; i++) begin
            if (BW'(i) == bit_cnt_q) code_bit = CODE[CODE_W-1-i];
        end
    end

    always_ff @(posedge CLK or negedge CLR_L) begin
        if (!CLR_L) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            match_q   <= 1'b1;
            fail_q    <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            match_q   <= match_d;
            fail_q    <= fail_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        match_d      = match_q;
        fail_d       = fail_q;
        tmr_load     = 1'b0;
        tmr_en       = 1'b0;
        tmr_val      = '0;
        attempt_done = 1'b0;
        attempt_ok   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (START) begin
                    state_d   = ENTER;
                    bit_cnt_d = '0;
                    match_d   = 1'b1;
`ifdef LOCK_ENTRY_TIMEOUT_EN
                    tmr_load  = 1'b1;
                    tmr_val   = TMO_LOAD;
`endif
                end
            end
            ENTER: begin
                if (X_VALID) begin
                    match_d   = match_q & (X == code_bit);
                    bit_cnt_d = bit_cnt_q + BW'(1);
                    if (bit_cnt_q == LAST_BIT) begin
                        attempt_done = 1'b1;
                        attempt_ok   = match_d;
                    end
`ifdef LOCK_ENTRY_TIMEOUT_EN
                    else begin
                        tmr_load = 1'b1;
                        tmr_val  = TMO_LOAD;
                    end
                end else if (tmr_zero) begin
                    attempt_done = 1'b1;
                end else begin
                    tmr_en = 1'b1;
`endif
                end
            end
            OPEN: begin
                if (tmr_zero) state_d = IDLE;
                else          tmr_en  = 1'b1;
            end
            LOCKOUT: begin
                if (tmr_zero) begin
                    state_d = IDLE;
                    fail_d  = '0;
                end else begin
                    tmr_en  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A timeout abort lands here with attempt_ok=0, exactly like a wrong code.
        if (attempt_done) begin
            if (attempt_ok) begin
                state_d  = OPEN;
                tmr_load = 1'b1;
                tmr_val  = UNLK_LOAD;
                fail_d   = '0;
            end else if (fail_q >= FW'(MAX_FAIL - 1)) begin
                state_d  = LOCKOUT;
                tmr_load = 1'b1;
                tmr_val  = LOCK_LOAD;
                fail_d   = FW'(MAX_FAIL);
            end else begin
                state_d  = IDLE;
                fail_d   = fail_q + FW'(1);
            end
        end
    end

    always_comb begin
        unlk_d   = (state_d == OPEN);
        locked_d = (state_d == LOCKOUT);
        busy_d   = (state_d != IDLE);
        hint_d   = (state_d == ENTER) && (bit_cnt_d != '0) && match_d;
    end

    always_ff @(posedge CLK or negedge CLR_L) begin
        if (!CLR_L) begin
            UNLK       <= 1'b0;
            HINT       <= 1'b0;
            LOCKED_OUT <= 1'b0;
            BUSY       <= 1'b0;
        end else begin
            UNLK       <= unlk_d;
            HINT       <= hint_d;
            LOCKED_OUT <= locked_d;
            BUSY       <= busy_d;
        end
    end

    assign FAIL_CNT = fail_q;

endmodule

// File: tb/tb_lock_sequence_controller.sv
// Directed bench for lock_sequence_controller at default parameters (CODE=1101).
// Covers the entry timeout when built with LOCK_ENTRY_TIMEOUT_EN.
module tb_lock_sequence_controller;

    logic       CLK = 1'b0;
    logic       CLR_L = 1'b1;
    logic       START = 1'b0;
    logic       X = 1'b0;
    logic       X_VALID = 1'b0;
    logic       UNLK, HINT, LOCKED_OUT, BUSY;
    logic [1:0] FAIL_CNT;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    lock_sequence_controller #(
        .CODE_W      (4),
        .CODE        (4'b1101),
        .MAX_FAIL    (3),
        .UNLK_CYC    (8),
        .LOCKOUT_CYC (16),
        .TIMEOUT_CYC (32)
    ) dut (
        .CLK        (CLK),
        .CLR_L      (CLR_L),
        .START      (START),
        .X          (X),
        .X_VALID    (X_VALID),
        .UNLK       (UNLK),
        .HINT,
        .LOCKED_OUT (LOCKED_OUT),
        .BUSY       (BUSY),
        .FAIL_CNT   (FAIL_CNT)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, sample 1 time unit after the rising edge.
    task automatic tick(input logic s, input logic v, input logic b);
        START = s; X_VALID = v; X = b;
        @(posedge CLK);
        #1;
        START = 1'b0; X_VALID = 1'b0; X = 1'b0;
    endtask

    task automatic bits4(input logic [3:0] c);
        for (int i = 3; i >= 0; i--) tick(1'b0, 1'b1, c[i]);
    endtask

    task automatic wrong_attempt(input int exp_fail);
        tick(1'b1, 1'b0, 1'b0);
        bits4(4'b1011);
        check("wrong_fail_cnt", FAIL_CNT, exp_fail);
        check("wrong_busy", BUSY, 0);
    endtask

    task automatic drain_unlock(input string tag);
        int hi;
        hi = 1;
        for (int k = 0; k < 12; k++) begin
            tick(1'b0, 1'b1, 1'b1);
            if (UNLK) hi++;
        end
        check({tag, "_unlk_cycles"}, hi, 8);
        check({tag, "_busy_after"}, BUSY, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 CLR_L = 1'b0;
        #1;
        check("rst_unlk", UNLK, 0);
        check("rst_hint", HINT, 0);
        check("rst_locked", LOCKED_OUT, 0);
        check("rst_busy", BUSY, 0);
        check("rst_fail", FAIL_CNT, 0);
        @(negedge CLK) CLR_L = 1'b1;

        // 1: correct code
        tick(1'b1, 1'b0, 1'b0);
        check("t1_busy", BUSY, 1);
        check("t1_hint0", HINT, 0);
        tick(1'b0, 1'b1, 1'b1); check("t1_hint1", HINT, 1);
        tick(1'b0, 1'b1, 1'b1); check("t1_hint2", HINT, 1);
        tick(1'b0, 1'b1, 1'b0); check("t1_hint3", HINT, 1);
        tick(1'b0, 1'b1, 1'b1);
        check("t1_unlk", UNLK, 1);
        check("t1_hint4", HINT, 0);
        check("t1_fail", FAIL_CNT, 0);
        drain_unlock("t1");

        // 2: wrong code 1011
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b1); check("t2_hint1", HINT, 1);
        tick(1'b0, 1'b1, 1'b0); check("t2_hint2", HINT, 0);
        tick(1'b0, 1'b1, 1'b1); check("t2_hint3", HINT, 0);
        tick(1'b0, 1'b1, 1'b1);
        check("t2_unlk", UNLK, 0);
        check("t2_busy", BUSY, 0);
        check("t2_fail", FAIL_CNT, 1);

        // 3: third failure triggers lockout; START ignored throughout
        wrong_attempt(2);
        tick(1'b1, 1'b0, 1'b0);
        bits4(4'b1011);
        check("t3_locked_start", LOCKED_OUT, 1);
        check("t3_fail_sat", FAIL_CNT, 3);
        check("t3_busy", BUSY, 1);
        for (int k = 1; k < 16; k++) begin
            tick(1'b1, 1'b0, 1'b0);
            check("t3_locked_hold", LOCKED_OUT, 1);
        end
        tick(1'b1, 1'b0, 1'b0);
        check("t3_locked_end", LOCKED_OUT, 0);
        check("t3_busy_end", BUSY, 0);
        check("t3_fail_clr", FAIL_CNT, 0);

        // 4: two failures then success; START during ENTER ignored
        wrong_attempt(1);
        wrong_attempt(2);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b1);
        tick(1'b1, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b0);
        check("t4_hint3", HINT, 1);
        tick(1'b0, 1'b1, 1'b1);
        check("t4_unlk", UNLK, 1);
        check("t4_fail_clr", FAIL_CNT, 0);
        drain_unlock("t4");

        // 5: async reset mid-ENTER and mid-OPEN; START+X_VALID in IDLE
        wrong_attempt(1);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b1);
        check("t5_hint_pre", HINT, 1);
        #1 CLR_L = 1'b0;
        #1;
        check("t5e_hint", HINT, 0);
        check("t5e_busy", BUSY, 0);
        check("t5e_fail", FAIL_CNT, 0);
        @(negedge CLK) CLR_L = 1'b1;
        tick(1'b1, 1'b0, 1'b0);
        bits4(4'b1101);
        check("t5_unlk_pre", UNLK, 1);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        check("t5_unlk_c3", UNLK, 1);
        #1 CLR_L = 1'b0;
        #1;
        check("t5o_unlk", UNLK, 0);
        check("t5o_busy", BUSY, 0);
        check("t5o_locked", LOCKED_OUT, 0);
        @(negedge CLK) CLR_L = 1'b1;
        tick(1'b0, 1'b1, 1'b1);
        check("t5_xv_idle_busy", BUSY, 0);
        tick(1'b1, 1'b1, 1'b0);
        check("t5_sx_busy", BUSY, 1);
        check("t5_sx_hint", HINT, 0);
        tick(1'b0, 1'b1, 1'b1); check("t5_sx_hint1", HINT, 1);
        tick(1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b0); check("t5_sx_hint3", HINT, 1);
        tick(1'b0, 1'b1, 1'b1);
        check("t5_sx_unlk", UNLK, 1);
        drain_unlock("t5");

`ifdef LOCK_ENTRY_TIMEOUT_EN
        // 6: timeout abort after 32 idle cycles, then bit on the expiry cycle wins
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 31; k++) tick(1'b0, 1'b0, 1'b0);
        check("t6_busy_31", BUSY, 1);
        check("t6_hint_31", HINT, 1);
        tick(1'b0, 1'b0, 1'b0);
        check("t6_abort_busy", BUSY, 0);
        check("t6_abort_hint", HINT, 0);
        check("t6_abort_fail", FAIL_CNT, 1);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 31; k++) tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b1);
        check("t6_edge_busy", BUSY, 1);
        check("t6_edge_hint", HINT, 1);
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b1);
        check("t6_edge_unlk", UNLK, 1);
        check("t6_edge_fail", FAIL_CNT, 0);
`else
        // 6: without timeout, ENTER waits indefinitely
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 40; k++) tick(1'b0, 1'b0, 1'b0);
        check("t6_wait_busy", BUSY, 1);
        check("t6_wait_hint", HINT, 1);
        bits4(4'b1010);
        check("t6_wait_unlk", UNLK, 1);
        check("t6_wait_fail", FAIL_CNT, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
